// File: rtl/kpscan_pkg.sv
// kpscan_pkg: shared constants and helpers for the keypad scanner
package kpscan_pkg;
  localparam int KP_NKEYS = 16;
  localparam int KP_EVT_W = 5;
  localparam int EVT_PRESS = 4;
  localparam int WB_VALID = 31;
  localparam int WB_POP = 31;
  localparam int WB_FLUSH = 30;
  function automatic logic [3:0] lowest_set(input logic [KP_NKEYS-1:0] v);
    lowest_set = '0;
    for (int i = KP_NKEYS - 1; i >= 0; i--) if (v[i]) lowest_set = 4'(i);
  endfunction
endpackage

// File: rtl/kpfifo.sv
// kpfifo: small synchronous event FIFO with push, pop and flush
module kpfifo #(
  parameter int LGFIFO = 2,
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int DEPTH = 1 << LGFIFO;
  logic [W-1:0] mem_q [DEPTH];
  logic [LGFIFO-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LGFIFO:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign o_empty = cnt_q == '0;
  assign o_full = cnt_q == (LGFIFO + 1)'(DEPTH);
  assign o_head = mem_q[rd_q];
  assign do_pop = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  // pointer and count next state; flush overrides any push or pop
  always_comb begin
    wr_d = i_flush ? '0 : wr_q + LGFIFO'(do_push);
    rd_d = i_flush ? '0 : rd_q + LGFIFO'(do_pop);
    cnt_d = i_flush ? '0 : cnt_q + (LGFIFO + 1)'(do_push) - (LGFIFO + 1)'(do_pop);
  end
  // pointer and count registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  // storage needs no reset; the head is only trusted when non-empty
  always_ff @(posedge i_clk)
    if (do_push && !i_flush) mem_q[wr_q] <= i_data;
endmodule

// File: rtl/kpscan.sv
// kpscan: 4x4 keypad scanner with frame debounce and press/release event FIFO
module kpscan
  import kpscan_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd8000,
  parameter int DEBOUNCE = 3,
  parameter int LGFIFO = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_kp_col,
  input  logic [3:0]  i_kp_row,
  output logic        o_kp_int
);
  logic [15:0] div_q, div_d;
  logic [1:0] col_q, col_d;
  logic [3:0] kcol_q, kcol_d, sync1_q, sync2_q, stab_q, stab_d, k;
  logic [KP_NKEYS-1:0] raw_q, raw_d, prev_q, km_q, km_d, diff;
  logic [KP_EVT_W-1:0] evt, head;
  logic tick, fd_q, stable, push_req, push, pop, flush, full, empty, int_q, unused;
  assign tick = div_q == SCAN_DIV - 16'd1;
  assign pop = i_wb_stb && i_wb_we && i_wb_data[WB_POP];
  assign flush = i_wb_stb && i_wb_we && i_wb_data[WB_FLUSH];
  assign unused = &{1'b0, i_wb_cyc, i_wb_data[29:0]};
  // divider, column drive and raw frame capture on each column step
  always_comb begin
    div_d = tick ? '0 : div_q + 16'd1;
    col_d = tick ? col_q + 2'd1 : col_q;
    kcol_d = tick ? ~(4'b1 << col_d) : kcol_q;
    raw_d = raw_q;
    if (tick) raw_d[{col_q, 2'b00} +: 4] = ~sync2_q;
  end
  // debounce count and lowest-index change selection for event generation
  always_comb begin
    stab_d = (raw_q != prev_q) ? '0 : (stab_q == 4'(DEBOUNCE)) ? stab_q : stab_q + 4'd1;
    stable = stab_d >= 4'(DEBOUNCE - 1);
    diff = raw_q ^ km_q;
    k = lowest_set(diff);
    evt = '0;
    evt[EVT_PRESS] = raw_q[k];
    evt[3:0] = k;
    push_req = fd_q && stable && |diff;
    push = push_req && !flush && (!full || pop);
    km_d = km_q;
    if (push) km_d[k] = raw_q[k];
  end
  // scanner, synchroniser, debounce and interrupt state
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      div_q <= '0;
      col_q <= '0;
      kcol_q <= 4'b1110;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      raw_q <= '0;
      prev_q <= '0;
      stab_q <= '0;
      km_q <= '0;
      fd_q <= 1'b0;
      int_q <= 1'b0;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      kcol_q <= kcol_d;
      sync1_q <= i_kp_row;
      sync2_q <= sync1_q;
      raw_q <= raw_d;
      fd_q <= tick && col_q == 2'd3;
      if (fd_q) prev_q <= raw_q;
      if (fd_q) stab_q <= stab_d;
      km_q <= km_d;
      int_q <= !empty;
    end
  kpfifo #(.LGFIFO(LGFIFO), .W(KP_EVT_W)) u_fifo (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_push(push),
    .i_pop(pop),
    .i_flush(flush),
    .i_data(evt),
    .o_full(full),
    .o_empty(empty),
    .o_head(head)
  );
  assign o_kp_col = kcol_q;
  assign o_kp_int = int_q;
  assign o_wb_data = {!empty, 10'h0, empty ? {KP_EVT_W{1'b0}} : head, km_q};
endmodule

// File: tb/tb_kpscan.sv
// tb_kpscan: table-driven and scoreboard checks of the keypad scanner
module tb_kpscan;
  logic clk = 1'b0, rst_n = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] col, row;
  logic kint;
  logic [15:0] keys = '0, km = '0;
  int n_cmp = 0, n_bad = 0;
  logic [4:0] exp_q[$];
  typedef struct { logic [15:0] keys; int nev; logic [9:0] evs; } vec_t;
  vec_t tbl[5];

  kpscan #(.SCAN_DIV(16'd4), .DEBOUNCE(3), .LGFIFO(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_data(wdata), .o_wb_data(rdata), .o_kp_col(col), .i_kp_row(row), .o_kp_int(kint)
  );

  always #5 clk = ~clk;

  // keypad model: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic align_frame();
    logic [3:0] p;
    bit ok;
    p = col;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 4'b0111 && col == 4'b1110);
      p = col;
    end
    if (!ok) timeout("align");
  endtask

  task automatic frames(input int n);
    repeat (n) align_frame();
  endtask

  task automatic wb_write(input logic [31:0] d);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; wdata = d;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; wdata = '0;
  endtask

  task automatic wait_valid(input string nm, output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = rdata[31];
    end
    if (!ok) timeout(nm);
  endtask

  task automatic check_next(input bit chk_km);
    bit ok;
    logic [4:0] e;
    wait_valid("evt_wait", ok);
    if (ok) begin
      if (exp_q.size() == 0) timeout("scoreboard_empty");
      else begin
        e = exp_q.pop_front();
        chk("evt", {27'h0, rdata[20:16]}, {27'h0, e});
        if (chk_km) begin
          km[e[3:0]] = e[4];
          chk("keymap", {16'h0, rdata[15:0]}, {16'h0, km});
        end
      end
      wb_write(32'h8000_0000);
    end
  endtask

  task automatic reset_release_check();
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("col_after_reset", {28'h0, col}, {28'h0, (i < 4) ? 4'b1110 : 4'b1101});
    end
  endtask

  initial begin
    bit ok;
    logic [4:0] e;
    tbl[0] = '{16'h0000, 1, {5'h00, 5'h06}};
    tbl[1] = '{16'h0204, 2, {5'h19, 5'h12}};
    tbl[2] = '{16'h0000, 2, {5'h09, 5'h02}};
    tbl[3] = '{16'h8001, 2, {5'h1F, 5'h10}};
    tbl[4] = '{16'h0000, 2, {5'h0F, 5'h00}};
    #1 rst_n = 0;
    #1;
    chk("rst_col", {28'h0, col}, 32'h0000_000E);
    chk("rst_wb", rdata, 32'h0);
    chk("rst_int", {31'h0, kint}, 32'h0);
    repeat (3) @(negedge clk);
    reset_release_check();

    // single press of key 6 (column 1, row 2)
    align_frame();
    keys = 16'h0040;
    exp_q.push_back(5'h16);
    wait_valid("press_wait", ok);
    if (ok) begin
      chk("press_wb", rdata, 32'h8016_0040);
      e = exp_q.pop_front();
      chk("press_sb", {27'h0, rdata[20:16]}, {27'h0, e});
      km = 16'h0040;
      chk("press_int_lag", {31'h0, kint}, 32'h0);
      @(negedge clk);
      chk("press_int", {31'h0, kint}, 32'h1);
      wb_write(32'h8000_0000);
      chk("pop_valid", {31'h0, rdata[31]}, 32'h0);
      chk("pop_int_hold", {31'h0, kint}, 32'h1);
      @(negedge clk);
      chk("pop_int_fall", {31'h0, kint}, 32'h0);
    end

    // table: release, multi-key ordering, boundary keys 0 and 15
    for (int i = 0; i < 5; i++) begin
      align_frame();
      keys = tbl[i].keys;
      for (int j = 0; j < tbl[i].nev; j++) exp_q.push_back(tbl[i].evs[j*5 +: 5]);
      for (int j = 0; j < tbl[i].nev; j++) check_next(1);
    end

    // bounce: key 6 toggles every frame, then holds
    for (int f = 0; f < 5; f++) begin
      align_frame();
      chk("bounce_quiet", {31'h0, rdata[31]}, 32'h0);
      keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
    end
    exp_q.push_back(5'h16);
    check_next(1);
    frames(4);
    chk("bounce_once", {31'h0, rdata[31]}, 32'h0);
    align_frame();
    keys = 16'h0000;
    exp_q.push_back(5'h06);
    check_next(1);

    // FIFO full: six changes, four queued, keymap lags
    align_frame();
    keys = 16'h003F;
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, 4'(i)});
    frames(14);
    chk("full_keymap_lag", {16'h0, rdata[15:0]}, 32'h0000_000F);
    chk("full_head", {27'h0, rdata[20:16]}, {27'h0, exp_q[0]});
    chk("full_int", {31'h0, kint}, 32'h1);
    // pop in the same cycle as a push-producing frame_done
    align_frame();
    cyc = 1; stb = 1; we = 1; wdata = 32'h8000_0000;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; wdata = '0;
    void'(exp_q.pop_front());
    chk("poppush_keymap", {16'h0, rdata[15:0]}, 32'h0000_001F);
    chk("poppush_head", {27'h0, rdata[20:16]}, {27'h0, exp_q[0]});
    frames(3);
    chk("poppush_still_full", {16'h0, rdata[15:0]}, 32'h0000_001F);
    for (int i = 0; i < 5; i++) check_next(0);
    chk("full_final_keymap", {16'h0, rdata[15:0]}, 32'h0000_003F);
    km = 16'h003F;

    // flush with three queued release events
    align_frame();
    keys = 16'h0038;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = rdata[15:0] == 16'h0038;
    end
    if (!ok) timeout("flush_fill");
    chk("flush_pre_head", {26'h0, rdata[31], rdata[20:16]}, 32'h0000_0020);
    wb_write(32'h4000_0000);
    chk("flush_wb", rdata, 32'h0000_0038);
    chk("flush_int_hold", {31'h0, kint}, 32'h1);
    @(negedge clk);
    chk("flush_int_fall", {31'h0, kint}, 32'h0);
    km = 16'h0038;
    frames(4);
    chk("flush_no_requeue", {31'h0, rdata[31]}, 32'h0);
    align_frame();
    keys = 16'h0000;
    for (int i = 3; i < 6; i++) exp_q.push_back({1'b0, 4'(i)});
    for (int i = 0; i < 3; i++) check_next(1);

    // reset mid-scan with an event pending
    align_frame();
    keys = 16'h0040;
    frames(5);
    chk("prereset_wb", rdata, 32'h8016_0040);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midrst_col", {28'h0, col}, 32'h0000_000E);
    chk("midrst_wb", rdata, 32'h0);
    chk("midrst_int", {31'h0, kint}, 32'h0);
    keys = 16'h0000;
    reset_release_check();
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kpscan.md
Name: kpscan

Overview:
Hardware scanner for the external 4x4 keypad: drives the column lines, samples the row lines, debounces whole-keypad frames and queues press/release events.
- Takes over the keypad pins from the software-driven column/row path of the simple I/O peripheral, so software no longer has to scan or debounce.
- Sits on the Wishbone I/O bus next to that peripheral and raises its own keypad interrupt to the interrupt controller.

Parameters:
SCAN_DIV, 16'd8000, clock cycles per column step (column settle time plus sample period); must be >= 2.
DEBOUNCE, 3, number of consecutive identical frames required before a frame counts as stable; range 1..15.
LGFIFO, 2, log2 of event FIFO depth (default 4 events).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_wb_cyc  in  1  Wireshbone cycle
i_wb_stb  in  1  Wishbone strobe (single register, no address)
i_wb_we  in  1  Wishbone write enable
i_wb_data  in  32  write data
o_wb_data  out  32  read data: {valid, 10'h0, press, key[3:0], keymap[15:0]}
o_kp_col  out  4  column drive, active low, exactly one column low
i_kp_row  in  4  row sense, pulled up, low means pressed
o_kp_int  out  1  high while the event FIFO is non-empty

Behaviour:
Reset:
- Reset is asynchronous on i_rst_n low, released synchronously.
- Reset values: o_kp_col=4'b1110; column index 0; divider 0; row synchronisers 4'hF; raw frame 0; previous frame 0; stable count 0; debounced keymap 0; FIFO empty; o_kp_int=0.

Synchronisation and scan:
- i_kp_row passes through a two-flop synchroniser.
- Divider counts 0..SCAN_DIV-1. On the terminal count (tick):
  - raw[col*4+r] <= ~row_sync[r], for r=0..3;
  - col <= col+1 mod 4;
  - o_kp_col <= ~(4'b1 << new col), registered.
- Key index = col*4 + row.
- A tick with col==3 completes a frame: frame_done pulses one cycle later, carrying the full 16-bit raw map.

Debounce on frame_done:
- If raw == prev: stable count increments, saturating at DEBOUNCE.
- Otherwise: stable count <= 0.
- prev <= raw.
- The frame is stable when stable count >= DEBOUNCE-1 after the compare (so DEBOUNCE=1 means every frame is stable).

Event generation:
- Occurs on a stable frame_done, and again on each following stable frame.
- diff = raw ^ keymap. If diff != 0, select the lowest set index k.
- If the FIFO is not full: push {press=raw[k], key=k} and set keymap[k] <= raw[k].
- If the FIFO is full: no push and keymap is unchanged, so the change is retried on the next stable frame and no event is lost.
- At most one event per frame.

FIFO and Wishbone:
- FIFO is 2^LGFIFO x 5 bits with wrapping pointers and a count of width LGFIFO+1.
- Read data is combinational from registered state, with zero wait states: valid = FIFO non-empty; press and key come from the FIFO head (0 when empty); keymap is the debounced map.
- Write (i_wb_stb && i_wb_we):
  - i_wb_data[31]=1 pops the head; a pop on an empty FIFO is ignored.
  - i_wb_data[30]=1 flushes the FIFO (pointers and count to 0).
- Same-cycle rules:
  - Push and pop together: both occur, count unchanged. If the FIFO is full, the pop frees space and the push is accepted.
  - Flush beats push and pop.
- i_wb_cyc is unused internally, matching the other bus peripherals.
- o_kp_int <= FIFO non-empty after the cycle's update (registered, one-cycle lag).

Boundary notes:
- Divider and column index wrap silently.
- Reset mid-scan restarts at column 0.
- Multiple keys changing in one frame produce events in ascending key order, one per stable frame.

Decomposition:
- Shared package: KP_NKEYS=16, KP_EVT_W=5, event field positions (press bit 4, key bits 3:0), and o_wb_data bit positions (valid 31, pop 31, flush 30).
- One sub-module, kpfifo: parameterised synchronous FIFO with push, pop, flush, full, empty, head and async active-low reset.
- Scanner, debounce and Wishbone logic stay in kpscan.

Test Plan:
- Reset: hold i_rst_n low mid-scan -> o_kp_col=4'b1110, o_wb_data=32'h0, o_kp_int=0 immediately; after release, column 0 stays low for SCAN_DIV cycles and then steps to 4'b1101.
- Single press: SCAN_DIV=4, DEBOUNCE=3; model key 6 (col 1, row 2) pressed -> after 3 identical frames, o_kp_int=1 and o_wb_data=32'h8016_0040; write 32'h8000_0000 -> valid=0 and o_kp_int falls one cycle later.
- Bounce: toggle key 6 every frame for 5 frames, then hold -> no event until 3 stable frames; exactly one press event.
- Multi-key and ordering: press keys 9 and 2 in the same frame -> events key 2, then key 9, on consecutive stable frames; release both -> release events 2, then 9 with press=0.
- FIFO full: LGFIFO=2; generate 5 changes without popping -> 4 events queued and keymap lags; pop once -> 5th event appears on the next stable frame; issue pop and a push-producing frame_done in the same cycle -> count unchanged.
- Flush: with 3 queued events, write 32'h4000_0000 -> valid=0; keymap is unchanged.
